dcache_axi_bridge: RTL and testbench

//  Converts the DCache refill/writeback bus (cache_bus r/w/b) into AXI4 master bursts.

---
 rtl/dcache_axi_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_dcache_axi_bridge.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
//   Bridges the DCache refill/writeback bus (cache_bus r/w/b) onto an AXI4
//   master. Read (refill) and write (writeback) paths are independent FSMs so a
//   dirty-victim writeback can overlap a refill. Each line is one INCR burst of
//   BEATS 64-bit beats. Beat position seen by both sides comes from internal
//   counters; protocol anomalies are reported through sticky error flags.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   c_r_*                 : cache refill request / beat strobe / data / last
//   c_w_*                 : cache writeback beats (valid/addr/data/last/ready)
//   c_b_ready, c_b_valid  : cache write-response handshake
//   m_ar*, m_r*           : AXI4 read address / read data channels
//   m_aw*, m_w*, m_b*     : AXI4 write address / write data / write response
//   rd_err                : sticky, RRESP != OKAY or RLAST in the wrong place
//   wr_err                : sticky, BRESP != OKAY
module dcache_axi_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned RD_ID  = 0,
  parameter int unsigned WR_ID  = 1,
  parameter int unsigned BEATS  = 2
) (
  input  logic              clock,
  input  logic              reset,
  // cache refill
  input  logic              c_r_valid,
  input  logic [63:0]       c_r_raddr,
  output logic              c_r_ready,
  output logic [63:0]       c_r_rdata,
  output logic              c_r_rlast,
  // cache writeback
  input  logic              c_w_valid,
  input  logic [63:0]       c_w_waddr,
  input  logic [63:0]       c_w_wdata,
  input  logic              c_w_wlast,
  output logic              c_w_ready,
  input  logic              c_b_ready,
  output logic              c_b_valid,
  // AXI read address
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W-1:0]   m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  // AXI read data
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [63:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  // AXI write address
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [ID_W-1:0]   m_awid,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  // AXI write data
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [63:0]       m_wdata,
  output logic [7:0]        m_wstrb,
  output logic              m_wlast,
  // AXI write response
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  // status
  output logic              rd_err,
  output logic              wr_err
);

  localparam int unsigned      OFF_W     = $clog2(BEATS * 8);
  localparam int unsigned      CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

  rd_state_e         rd_state_q, rd_state_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              rd_err_q, rd_err_d;
  logic              wr_err_q, wr_err_d;

  // Address bits above ADDR_W and below the line offset are dropped; the
  // cache's own wlast is ignored because beat position comes from wcnt.
  logic unused_inputs;
  assign unused_inputs = ^{c_r_raddr[63:ADDR_W], c_r_raddr[OFF_W-1:0],
                           c_w_waddr[63:ADDR_W], c_w_waddr[OFF_W-1:0], c_w_wlast};

  // Fixed burst attributes; addresses come straight from registers so they
  // stay stable while valid is held.
  assign m_araddr  = araddr_q;
  assign m_arid    = ID_W'(RD_ID);
  assign m_arlen   = 8'(BEATS - 1);
  assign m_arsize  = 3'd3;
  assign m_arburst = 2'b01;
  assign m_awaddr  = awaddr_q;
  assign m_awid    = ID_W'(WR_ID);
  assign m_awlen   = 8'(BEATS - 1);
  assign m_awsize  = 3'd3;
  assign m_awburst = 2'b01;
  assign m_wstrb   = 8'hFF;
  assign m_wdata   = c_w_wdata;
  assign c_r_rdata = m_rdata;
  assign rd_err    = rd_err_q;
  assign wr_err    = wr_err_q;

  // Read path
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rcnt_d     = rcnt_q;
    rd_err_d   = rd_err_q;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    c_r_ready  = 1'b0;
    c_r_rlast  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (c_r_valid) begin
          araddr_d   = {c_r_raddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          rcnt_d     = '0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        m_rready  = 1'b1;
        c_r_ready = m_rvalid;
        c_r_rlast = (rcnt_q == LAST_BEAT);
        if (m_rvalid) begin
          if ((m_rlast != (rcnt_q == LAST_BEAT)) || (m_rresp != 2'b00)) begin
            rd_err_d = 1'b1;
          end
          rcnt_d = rcnt_q + CNT_W'(1);
          if (rcnt_q == LAST_BEAT) begin
            rd_state_d = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write path
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wcnt_d     = wcnt_q;
    wr_err_d   = wr_err_q;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_wlast    = 1'b0;
    c_w_ready  = 1'b0;
    m_bready   = 1'b0;
    c_b_valid  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (c_w_valid) begin
          awaddr_d   = {c_w_waddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) begin
          wcnt_d     = '0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        m_wvalid  = c_w_valid;
        m_wlast   = (wcnt_q == LAST_BEAT);
        c_w_ready = m_wready;
        if (c_w_valid && m_wready) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (wcnt_q == LAST_BEAT) begin
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        m_bready  = c_b_ready;
        c_b_valid = m_bvalid;
        if (m_bvalid && c_b_ready) begin
          if (m_bresp != 2'b00) begin
            wr_err_d = 1'b1;
          end
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      rcnt_q     <= '0;
      wcnt_q     <= '0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      araddr_q   <= araddr_d;
      awaddr_q   <= awaddr_d;
      rcnt_q     <= rcnt_d;
      wcnt_q     <= wcnt_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
module tb_dcache_axi_bridge;
  logic        clock = 1'b0;
  logic        reset;
  logic        c_r_valid, c_r_ready, c_r_rlast;
  logic [63:0] c_r_raddr, c_r_rdata;
  logic        c_w_valid, c_w_wlast, c_w_ready, c_b_ready, c_b_valid;
  logic [63:0] c_w_waddr, c_w_wdata;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready, m_rlast;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_wvalid, m_wready, m_wlast;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        rd_err, wr_err;

  always #5 clock = ~clock;

  dcache_axi_bridge dut (
    .clock(clock), .reset(reset),
    .c_r_valid(c_r_valid), .c_r_raddr(c_r_raddr), .c_r_ready(c_r_ready),
    .c_r_rdata(c_r_rdata), .c_r_rlast(c_r_rlast),
    .c_w_valid(c_w_valid), .c_w_waddr(c_w_waddr), .c_w_wdata(c_w_wdata),
    .c_w_wlast(c_w_wlast), .c_w_ready(c_w_ready),
    .c_b_ready(c_b_ready), .c_b_valid(c_b_valid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .rd_err(rd_err), .wr_err(wr_err)
  );

  int errors = 0;
  int checks = 0;
  int drv_timeout = 0;

  // Monitor: records handshakes on both sides for later comparison.
  int          cyc = 0;
  int          b_cnt = 0;
  int          cb_cnt = 0;
  int          both_cnt = 0;
  logic [64:0] rq[$];          // {c_r_rlast, c_r_rdata} per cache refill beat
  logic [64:0] wq[$];          // {m_wlast, m_wdata} per AXI W beat
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  int          ar_time_q[$];
  int          rlast_time_q[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (m_arvalid && m_arready) begin ar_q.push_back(m_araddr); ar_time_q.push_back(cyc); end
    if (m_awvalid && m_awready) aw_q.push_back(m_awaddr);
    if (c_r_valid && c_r_ready) begin
      rq.push_back({c_r_rlast, c_r_rdata});
      if (c_r_rlast) rlast_time_q.push_back(cyc);
    end
    if (m_wvalid && m_wready) wq.push_back({m_wlast, m_wdata});
    if (m_bvalid && m_bready) b_cnt <= b_cnt + 1;
    if (c_b_valid && c_b_ready) cb_cnt <= cb_cnt + 1;
    if (m_arvalid && m_awvalid) both_cnt <= both_cnt + 1;
  end

  // Stimulus-only drivers: cache + slave for one refill / one writeback.
  task automatic read_burst(input logic [63:0] addr, input int ar_wait,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic l0, input logic [1:0] resp0);
    int n;
    @(negedge clock);
    c_r_valid = 1'b1; c_r_raddr = addr;
    n = 0;
    do begin @(negedge clock); n++; end while (!m_arvalid && n < 20);
    if (!m_arvalid) drv_timeout++;
    repeat (ar_wait) @(negedge clock);
    m_arready = 1'b1;
    @(negedge clock);
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = d0; m_rlast = l0; m_rresp = resp0;
    @(negedge clock);
    m_rdata = d1; m_rlast = 1'b1; m_rresp = 2'b00;
    @(negedge clock);
    m_rvalid = 1'b0; m_rlast = 1'b0; c_r_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [63:0] addr, input int aw_wait, input int w_stall,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input int b_wait, input logic [1:0] bresp);
    int n;
    @(negedge clock);
    c_w_valid = 1'b1; c_w_waddr = addr; c_w_wdata = d0; c_w_wlast = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!m_awvalid && n < 20);
    if (!m_awvalid) drv_timeout++;
    repeat (aw_wait) @(negedge clock);
    m_awready = 1'b1;
    @(negedge clock);
    m_awready = 1'b0;
    repeat (w_stall) @(negedge clock);
    m_wready = 1'b1;
    @(negedge clock);
    c_w_wdata = d1; c_w_wlast = 1'b1;
    @(negedge clock);
    m_wready = 1'b0; c_w_valid = 1'b0; c_w_wlast = 1'b0; c_b_ready = 1'b1;
    repeat (b_wait) @(negedge clock);
    m_bvalid = 1'b1; m_bresp = bresp;
    @(negedge clock);
    m_bvalid = 1'b0; c_b_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0; #1;
    checks++;
    if ({m_arvalid, m_rready, c_r_ready, c_r_rlast, m_awvalid, m_wvalid, c_w_ready,
         m_wlast, m_bready, c_b_valid, rd_err, wr_err} !== 12'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {m_arvalid, m_rready, c_r_ready,
               c_r_rlast, m_awvalid, m_wvalid, c_w_ready, m_wlast, m_bready, c_b_valid, rd_err, wr_err});
    end
    checks++;
    if ({m_arsize, m_arburst, m_arlen, m_arid, m_awsize, m_awburst, m_awlen, m_awid, m_wstrb}
        !== {3'd3, 2'b01, 8'd1, 4'd0, 3'd3, 2'b01, 8'd1, 4'd1, 8'hFF}) begin
      errors++;
      $display("FAIL fixed_fields: got %h expected %h", {m_arsize, m_arburst, m_arlen, m_arid,
               m_awsize, m_awburst, m_awlen, m_awid, m_wstrb},
               {3'd3, 2'b01, 8'd1, 4'd0, 3'd3, 2'b01, 8'd1, 4'd1, 8'hFF});
    end
  endtask

  task automatic test_refill();
    int ab = ar_q.size();
    int rb = rq.size();
    @(negedge clock);
    c_r_valid = 1'b1; c_r_raddr = 64'h0000_0000_8000_0010; #1;
    checks++;
    if (m_arvalid !== 1'b0) begin errors++; $display("FAIL t1_ar_latency: got %b expected 0", m_arvalid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      m_arready = (i == 2); #1;
      checks++;
      if ({m_arvalid, m_araddr, m_arlen, c_r_ready} !== {1'b1, 32'h8000_0010, 8'd1, 1'b0}) begin
        errors++;
        $display("FAIL t1_ar_hold%0d: got %h expected %h", i, {m_arvalid, m_araddr, m_arlen, c_r_ready},
                 {1'b1, 32'h8000_0010, 8'd1, 1'b0});
      end
    end
    @(negedge clock);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hAAAA_0000_0000_000A; m_rlast = 1'b0; #1;
    checks++;
    if ({m_rready, c_r_ready, c_r_rlast, c_r_rdata} !== {1'b1, 1'b1, 1'b0, 64'hAAAA_0000_0000_000A}) begin
      errors++;
      $display("FAIL t1_beat0: got %h expected %h", {m_rready, c_r_ready, c_r_rlast, c_r_rdata},
               {1'b1, 1'b1, 1'b0, 64'hAAAA_0000_0000_000A});
    end
    @(negedge clock);
    m_rdata = 64'hBBBB_0000_0000_000B; m_rlast = 1'b1; #1;
    checks++;
    if ({c_r_ready, c_r_rlast, c_r_rdata} !== {1'b1, 1'b1, 64'hBBBB_0000_0000_000B}) begin
      errors++;
      $display("FAIL t1_beat1: got %h expected %h", {c_r_ready, c_r_rlast, c_r_rdata},
               {1'b1, 1'b1, 64'hBBBB_0000_0000_000B});
    end
    @(negedge clock);
    m_rvalid = 1'b0; m_rlast = 1'b0; c_r_valid = 1'b0; #1;
    checks++;
    if ({m_rready, c_r_rlast, m_arvalid, rd_err} !== 4'b0) begin
      errors++; $display("FAIL t1_idle_after: got %b expected 0", {m_rready, c_r_rlast, m_arvalid, rd_err});
    end
    checks++;
    if ((ar_q.size() - ab) !== 1 || (rq.size() - rb) !== 2) begin
      errors++;
      $display("FAIL t1_counts: got ar=%0d beats=%0d expected ar=1 beats=2", ar_q.size() - ab, rq.size() - rb);
    end
  endtask

  task automatic test_writeback();
    int wb = wq.size();
    int cbb = cb_cnt;
    @(negedge clock);
    c_w_valid = 1'b1; c_w_waddr = 64'h0000_0000_8000_0400;
    c_w_wdata = 64'hCCCC_0000_0000_000C; c_w_wlast = 1'b0; #1;
    checks++;
    if (m_awvalid !== 1'b0) begin errors++; $display("FAIL t2_aw_latency: got %b expected 0", m_awvalid); end
    @(negedge clock);
    m_awready = 1'b1; m_wready = 1'b1; #1;
    checks++;
    if ({m_awvalid, m_awaddr, m_awlen, m_awid, m_wvalid, c_w_ready}
        !== {1'b1, 32'h8000_0400, 8'd1, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL t2_aw_before_w: got %h expected %h", {m_awvalid, m_awaddr, m_awlen, m_awid, m_wvalid, c_w_ready},
               {1'b1, 32'h8000_0400, 8'd1, 4'd1, 1'b0, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      m_awready = 1'b0; m_wready = 1'b0; #1;
      checks++;
      if ({m_awvalid, m_wvalid, m_wlast, c_w_ready, m_wdata} !== {4'b0100, 64'hCCCC_0000_0000_000C}) begin
        errors++;
        $display("FAIL t2_stall%0d: got %h expected %h", i, {m_awvalid, m_wvalid, m_wlast, c_w_ready, m_wdata},
                 {4'b0100, 64'hCCCC_0000_0000_000C});
      end
    end
    @(negedge clock);
    m_wready = 1'b1; #1;
    checks++;
    if ({c_w_ready, m_wlast, m_wdata} !== {2'b10, 64'hCCCC_0000_0000_000C}) begin
      errors++; $display("FAIL t2_beat0: got %h expected %h", {c_w_ready, m_wlast, m_wdata}, {2'b10, 64'hCCCC_0000_0000_000C});
    end
    @(negedge clock);
    c_w_wdata = 64'hDDDD_0000_0000_000D; c_w_wlast = 1'b1; #1;
    checks++;
    if ({m_wvalid, m_wlast, m_wdata} !== {2'b11, 64'hDDDD_0000_0000_000D}) begin
      errors++; $display("FAIL t2_beat1: got %h expected %h", {m_wvalid, m_wlast, m_wdata}, {2'b11, 64'hDDDD_0000_0000_000D});
    end
    @(negedge clock);
    m_wready = 1'b0; c_w_valid = 1'b0; c_w_wlast = 1'b0; c_b_ready = 1'b1; #1;
    checks++;
    if ({m_wvalid, m_bready, c_b_valid} !== 3'b010) begin
      errors++; $display("FAIL t2_resp_wait: got %b expected 010", {m_wvalid, m_bready, c_b_valid});
    end
    @(negedge clock);
    m_bvalid = 1'b1; m_bresp = 2'b00; #1;
    checks++;
    if (c_b_valid !== 1'b1) begin errors++; $display("FAIL t2_b_valid: got %b expected 1", c_b_valid); end
    @(negedge clock);
    m_bvalid = 1'b0; c_b_ready = 1'b0; #1;
    checks++;
    if ({c_b_valid, m_bready, wr_err, m_awvalid} !== 4'b0) begin
      errors++; $display("FAIL t2_idle_after: got %b expected 0", {c_b_valid, m_bready, wr_err, m_awvalid});
    end
    checks++;
    if ((wq.size() - wb) !== 2 || (cb_cnt - cbb) !== 1) begin
      errors++; $display("FAIL t2_counts: got w=%0d b=%0d expected w=2 b=1", wq.size() - wb, cb_cnt - cbb);
    end
    checks++;
    if (wq[wb] !== {1'b0, 64'hCCCC_0000_0000_000C} || wq[wb+1] !== {1'b1, 64'hDDDD_0000_0000_000D}) begin
      errors++; $display("FAIL t2_w_beats: got %h %h expected C(last0) D(last1)", wq[wb], wq[wb+1]);
    end
  endtask

  task automatic test_dirty_eviction();
    int ab = ar_q.size();
    int awb = aw_q.size();
    int rb = rq.size();
    int wb = wq.size();
    int bb = b_cnt;
    int bothb = both_cnt;
    fork
      read_burst(64'h0000_0000_8000_0040, 0, 64'hEEEE, 64'h6666, 1'b0, 2'b00);
      write_burst(64'h0000_0000_8000_0080, 0, 0, 64'hFFFF, 64'h8888, 0, 2'b00);
    join
    @(negedge clock);
    checks++;
    if ((both_cnt - bothb) !== 1) begin errors++; $display("FAIL t3_ar_aw_same_cycle: got %0d expected 1", both_cnt - bothb); end
    checks++;
    if ((ar_q.size() - ab) !== 1 || (aw_q.size() - awb) !== 1 || (b_cnt - bb) !== 1) begin
      errors++; $display("FAIL t3_addr_counts: got ar=%0d aw=%0d b=%0d expected 1 1 1",
                         ar_q.size() - ab, aw_q.size() - awb, b_cnt - bb);
    end
    checks++;
    if (ar_q[ab] !== 32'h8000_0040 || aw_q[awb] !== 32'h8000_0080) begin
      errors++; $display("FAIL t3_addrs: got ar=%h aw=%h expected 80000040 80000080", ar_q[ab], aw_q[awb]);
    end
    checks++;
    if ((rq.size() - rb) !== 2 || rq[rb] !== {1'b0, 64'hEEEE} || rq[rb+1] !== {1'b1, 64'h6666}) begin
      errors++; $display("FAIL t3_r_beats: got n=%0d %h %h expected 2 EEEE(last0) 6666(last1)", rq.size() - rb, rq[rb], rq[rb+1]);
    end
    checks++;
    if ((wq.size() - wb) !== 2 || wq[wb] !== {1'b0, 64'hFFFF} || wq[wb+1] !== {1'b1, 64'h8888}) begin
      errors++; $display("FAIL t3_w_beats: got n=%0d %h %h expected 2 FFFF(last0) 8888(last1)", wq.size() - wb, wq[wb], wq[wb+1]);
    end
  endtask

  task automatic test_read_error();
    int rb = rq.size();
    read_burst(64'h0000_0000_8000_0020, 1, 64'h1111, 64'h2222, 1'b1, 2'b10);
    #1;
    checks++;
    if ((rq.size() - rb) !== 2 || rq[rb][64] !== 1'b0 || rq[rb+1][64] !== 1'b1) begin
      errors++; $display("FAIL t4_cache_rlast: got n=%0d last=%b%b expected n=2 last=01",
                         rq.size() - rb, rq[rb][64], rq[rb+1][64]);
    end
    checks++;
    if (rd_err !== 1'b1) begin errors++; $display("FAIL t4_rd_err_set: got %b expected 1", rd_err); end
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({rd_err, wr_err} !== 2'b10) begin errors++; $display("FAIL t4_rd_err_sticky: got %b expected 10", {rd_err, wr_err}); end
  endtask

  task automatic test_mid_burst_reset();
    int ab;
    int rb;
    @(negedge clock);
    c_r_valid = 1'b1; c_r_raddr = 64'h0000_0000_0000_0300;
    @(negedge clock);
    m_arready = 1'b1;
    @(negedge clock);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h3333; m_rlast = 1'b0; m_rresp = 2'b00;
    @(negedge clock);
    reset = 1'b1; m_rvalid = 1'b0; c_r_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0; m_rvalid = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; c_b_ready = 1'b1; #1;
    checks++;
    if ({m_arvalid, m_rready, c_r_ready, c_r_rlast, m_awvalid, m_wvalid, c_w_ready,
         m_bready, c_b_valid, rd_err, wr_err} !== 11'b0) begin
      errors++;
      $display("FAIL t5_after_reset: got %b expected 0", {m_arvalid, m_rready, c_r_ready, c_r_rlast,
               m_awvalid, m_wvalid, c_w_ready, m_bready, c_b_valid, rd_err, wr_err});
    end
    @(negedge clock);
    m_rvalid = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; c_b_ready = 1'b0;
    ab = ar_q.size();
    rb = rq.size();
    read_burst(64'h0000_0000_8000_0500, 0, 64'h5555, 64'h7777, 1'b0, 2'b00);
    #1;
    checks++;
    if ((ar_q.size() - ab) !== 1 || ar_q[ab] !== 32'h8000_0500) begin
      errors++; $display("FAIL t5_new_ar: got n=%0d addr=%h expected 1 80000500", ar_q.size() - ab, ar_q[ab]);
    end
    checks++;
    if ((rq.size() - rb) !== 2 || rq[rb] !== {1'b0, 64'h5555} || rq[rb+1] !== {1'b1, 64'h7777} || rd_err !== 1'b0) begin
      errors++; $display("FAIL t5_new_refill: got n=%0d %h %h err=%b expected 2 5555 7777(last) 0",
                         rq.size() - rb, rq[rb], rq[rb+1], rd_err);
    end
  endtask

  task automatic test_back_to_back();
    int ab = ar_q.size();
    int rb = rq.size();
    int lb = rlast_time_q.size();
    read_burst(64'h0000_0001_0000_0108, 0, 64'hA1, 64'hA2, 1'b0, 2'b00);
    read_burst(64'h0000_0000_0000_020C, 2, 64'hB1, 64'hB2, 1'b0, 2'b00);
    #1;
    checks++;
    if ((ar_q.size() - ab) !== 2 || ar_q[ab] !== 32'h0000_0100 || ar_q[ab+1] !== 32'h0000_0200) begin
      errors++; $display("FAIL t6_aligned_addrs: got n=%0d %h %h expected 2 00000100 00000200",
                         ar_q.size() - ab, ar_q[ab], ar_q[ab+1]);
    end
    checks++;
    if (ar_time_q[ab+1] <= rlast_time_q[lb]) begin
      errors++; $display("FAIL t6_ar_order: got ar2 at %0d first rlast at %0d expected ar2 later",
                         ar_time_q[ab+1], rlast_time_q[lb]);
    end
    checks++;
    if ((rq.size() - rb) !== 4 || {rq[rb][64], rq[rb+1][64], rq[rb+2][64], rq[rb+3][64]} !== 4'b0101) begin
      errors++; $display("FAIL t6_rlast_pattern: got n=%0d %b%b%b%b expected 4 0101", rq.size() - rb,
                         rq[rb][64], rq[rb+1][64], rq[rb+2][64], rq[rb+3][64]);
    end
  endtask

  task automatic test_write_error();
    int wb = wq.size();
    write_burst(64'h0000_0000_8000_0600, 1, 1, 64'h9999, 64'hABCD, 1, 2'b10);
    #1;
    checks++;
    if ({wr_err, rd_err} !== 2'b10) begin errors++; $display("FAIL t7_wr_err: got %b expected 10", {wr_err, rd_err}); end
    checks++;
    if ((wq.size() - wb) !== 2 || wq[wb+1] !== {1'b1, 64'hABCD}) begin
      errors++; $display("FAIL t7_w_beats: got n=%0d %h expected 2 ABCD(last)", wq.size() - wb, wq[wb+1]);
    end
    checks++;
    if (drv_timeout !== 0) begin errors++; $display("FAIL drv_timeout: got %0d expected 0", drv_timeout); end
  endtask

  initial begin
    reset = 1'b1;
    c_r_valid = 1'b0; c_r_raddr = '0;
    c_w_valid = 1'b0; c_w_waddr = '0; c_w_wdata = '0; c_w_wlast = 1'b0; c_b_ready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    test_reset();
    test_refill();
    test_writeback();
    test_dirty_eviction();
    test_read_error();
    test_mid_burst_reset();
    test_back_to_back();
    test_write_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
